// File: rtl/usb_bus_reset_detector_if.sv
// Line-side bundle of the USB bus reset detector: raw D+/D- in, decoded
// line state plus reset/suspend indications out.
interface usb_bus_reset_detector_if;
    logic       dp_raw;
    logic       dm_raw;
    logic [1:0] line_state;
    logic       bus_reset;
    logic       reset_start;
    logic       reset_end;
    logic       suspend;
    logic       resume;

    modport slave (
        input  dp_raw, dm_raw,
        output line_state, bus_reset, reset_start, reset_end, suspend, resume
    );

    modport master (
        output dp_raw, dm_raw,
        input  line_state, bus_reset, reset_start, reset_end, suspend, resume
    );
endinterface

// File: rtl/usb_bus_reset_detector.sv
// USB full-speed bus reset detector (device side); suspend/resume detection is
// compiled in only when USB_SUSPEND_DETECT_EN is defined.
module usb_bus_reset_detector #(
    parameter int RESET_MIN_CYCLES = 120,
    parameter int SUSPEND_CYCLES   = 144000
) (
    input  logic                        clk,
    input  logic                        rst_in,
    usb_bus_reset_detector_if.slave     bus
);
    localparam logic [1:0] LS_J   = 2'b10;
    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam int         SE0_W  = $clog2(RESET_MIN_CYCLES + 1);
    localparam logic [SE0_W-1:0] SE0_MAX  = SE0_W'(RESET_MIN_CYCLES);
    localparam logic [SE0_W-1:0] SE0_LAST = SE0_W'(RESET_MIN_CYCLES - 1);

    if (RESET_MIN_CYCLES < 2 || SUSPEND_CYCLES < 1) begin : g_param_check
        $error("usb_bus_reset_detector: RESET_MIN_CYCLES must be >= 2 and SUSPEND_CYCLES >= 1");
    end

    typedef enum logic [1:0] {IDLE, SE0_CNT, IN_RESET, SUSPENDED} state_t;

    state_t           state_q, state_d;
    logic [1:0]       sync1_q, sync2_q;
    logic [SE0_W-1:0] se0_cnt_q, se0_cnt_d;
    logic             bus_reset_q, bus_reset_d;
    logic             reset_start_q, reset_start_d;
    logic             reset_end_q, reset_end_d;
    logic             se0;

    assign se0 = (sync2_q == LS_SE0);

    // Any non-SE0 cycle (SE1 included) restarts reset qualification.
    always_comb begin
        se0_cnt_d = '0;
        if (se0) begin
            se0_cnt_d = (se0_cnt_q == SE0_MAX) ? se0_cnt_q : se0_cnt_q + 1'b1;
        end
    end

`ifdef USB_SUSPEND_DETECT_EN
    localparam logic [1:0]     LS_K   = 2'b01;
    localparam int             J_W    = $clog2(SUSPEND_CYCLES + 1);
    localparam logic [J_W-1:0] J_MAX  = J_W'(SUSPEND_CYCLES);
    localparam logic [J_W-1:0] J_LAST = J_W'(SUSPEND_CYCLES - 1);

    logic [J_W-1:0] j_cnt_q, j_cnt_d;
    logic           suspend_q, suspend_d;
    logic           resume_q, resume_d;
    logic           j_line, k_line;

    assign j_line = (sync2_q == LS_J);
    assign k_line = (sync2_q == LS_K);

    always_comb begin
        j_cnt_d = '0;
        if (j_line) begin
            j_cnt_d = (state_q == IDLE && j_cnt_q != J_MAX) ? j_cnt_q + 1'b1 : j_cnt_q;
        end
    end
`endif

    always_comb begin
        state_d       = state_q;
        reset_start_d = 1'b0;
        reset_end_d   = 1'b0;
`ifdef USB_SUSPEND_DETECT_EN
        resume_d      = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (se0) begin
                    state_d = SE0_CNT;
                end
`ifdef USB_SUSPEND_DETECT_EN
                else if (j_line && j_cnt_q == J_LAST) begin
                    state_d = SUSPENDED;
                end
`endif
            end
            SE0_CNT: begin
                if (!se0) begin
                    state_d = IDLE;
                end else if (se0_cnt_q == SE0_LAST) begin
                    state_d       = IN_RESET;
                    reset_start_d = 1'b1;
                end
            end
            IN_RESET: begin
                if (!se0) begin
                    state_d     = IDLE;
                    reset_end_d = 1'b1;
                end
            end
`ifdef USB_SUSPEND_DETECT_EN
            SUSPENDED: begin
                // SE0 while suspended counts as the first cycle of a possible reset.
                if (k_line) begin
                    state_d  = IDLE;
                    resume_d = 1'b1;
                end else if (se0) begin
                    state_d  = SE0_CNT;
                    resume_d = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        bus_reset_d = (state_d == IN_RESET);
`ifdef USB_SUSPEND_DETECT_EN
        suspend_d   = (state_d == SUSPENDED);
`endif
    end

    // Synchronizers reset to J so release never looks like the start of SE0.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            sync1_q       <= LS_J;
            sync2_q       <= LS_J;
            state_q       <= IDLE;
            se0_cnt_q     <= '0;
            bus_reset_q   <= 1'b0;
            reset_start_q <= 1'b0;
            reset_end_q   <= 1'b0;
`ifdef USB_SUSPEND_DETECT_EN
            j_cnt_q       <= '0;
            suspend_q     <= 1'b0;
            resume_q      <= 1'b0;
`endif
        end else begin
            sync1_q       <= {bus.dp_raw, bus.dm_raw};
            sync2_q       <= sync1_q;
            state_q       <= state_d;
            se0_cnt_q     <= se0_cnt_d;
            bus_reset_q   <= bus_reset_d;
            reset_start_q <= reset_start_d;
            reset_end_q   <= reset_end_d;
`ifdef USB_SUSPEND_DETECT_EN
            j_cnt_q       <= j_cnt_d;
            suspend_q     <= suspend_d;
            resume_q      <= resume_d;
`endif
        end
    end

    assign bus.line_state  = sync2_q;
    assign bus.bus_reset   = bus_reset_q;
    assign bus.reset_start = reset_start_q;
    assign bus.reset_end   = reset_end_q;
`ifdef USB_SUSPEND_DETECT_EN
    assign bus.suspend     = suspend_q;
    assign bus.resume      = resume_q;
`else
    assign bus.suspend     = 1'b0;
    assign bus.resume      = 1'b0;
`endif

endmodule

// File: tb/tb_usb_bus_reset_detector.sv
// Directed bench for usb_bus_reset_detector with a cycle-level reference model
// built from SE0/J run lengths seen two cycles after the pins.
module tb_usb_bus_reset_detector;
    localparam int RMIN = 120;
    localparam int SUSP = 300;
    localparam logic [1:0] J = 2'b10, K = 2'b01, SE0 = 2'b00, SE1 = 2'b11;

    logic clk = 1'b0;
    logic rst_in = 1'b0;
    always #5 clk = ~clk;

    usb_bus_reset_detector_if bus_if();

    usb_bus_reset_detector #(.RESET_MIN_CYCLES(RMIN), .SUSPEND_CYCLES(SUSP)) u_dut (
        .clk    (clk),
        .rst_in (rst_in),
        .bus    (bus_if)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: pins reach line_state one edge later and the decision
    // logic one edge after that; everything else follows from run lengths.
    logic [1:0] pipe_q[$];
    int         se0_run, j_run;
    bit         m_susp;
    logic [1:0] prev_obs;
    logic [1:0] m_line;
    bit         m_br, m_rs, m_re, m_su, m_rm;

    task automatic model_init();
        pipe_q   = {J, J};
        se0_run  = 0;
        j_run    = 0;
        m_susp   = 0;
        prev_obs = J;
    endtask

    task automatic model_step(input logic [1:0] pin);
        logic [1:0] obs;
        int prev_run;
        obs    = pipe_q[0];
        m_line = pipe_q[1];
        pipe_q.push_back(pin);
        void'(pipe_q.pop_front());
        prev_run = se0_run;
        se0_run  = (obs == SE0) ? se0_run + 1 : 0;
        m_br = (se0_run >= RMIN);
        m_rs = (se0_run == RMIN);
        m_re = (se0_run == 0) && (prev_run >= RMIN);
        m_rm = 0;
`ifdef USB_SUSPEND_DETECT_EN
        if (m_susp) begin
            m_rm = (obs == K) || (obs == SE0);
            if (m_rm) begin
                m_susp = 0;
                j_run  = 0;
            end
        end else begin
            // The J that ends an SE0 run is seen outside idle and is not counted.
            if (obs == J) j_run = (prev_obs == SE0) ? 0 : j_run + 1;
            else          j_run = 0;
            if (obs == J && j_run >= SUSP) m_susp = 1;
        end
`endif
        m_su = m_susp;
        prev_obs = obs;
    endtask

    initial begin
        model_init();
        forever begin
            @(posedge clk);
            if (!rst_in) begin
                model_init();
            end else begin
                model_step({bus_if.dp_raw, bus_if.dm_raw});
                #1;
                if (rst_in) begin
                    check("line_state",  int'(bus_if.line_state),  int'(m_line));
                    check("bus_reset",   int'(bus_if.bus_reset),   int'(m_br));
                    check("reset_start", int'(bus_if.reset_start), int'(m_rs));
                    check("reset_end",   int'(bus_if.reset_end),   int'(m_re));
                    check("suspend",     int'(bus_if.suspend),     int'(m_su));
                    check("resume",      int'(bus_if.resume),      int'(m_rm));
                end
            end
        end
    end

    task automatic step(input logic [1:0] ls);
        @(negedge clk);
        {bus_if.dp_raw, bus_if.dm_raw} = ls;
        @(posedge clk);
        #1;
    endtask

    task automatic watch(input logic [1:0] ls, input int n, inout int seen);
        for (int i = 0; i < n; i++) begin
            step(ls);
            if (bus_if.bus_reset || bus_if.reset_start || bus_if.reset_end) seen++;
        end
    endtask

    task automatic check_all_idle(input string tag);
        check({tag, "_line_state"},  int'(bus_if.line_state), int'(J));
        check({tag, "_bus_reset"},   int'(bus_if.bus_reset),   0);
        check({tag, "_reset_start"}, int'(bus_if.reset_start), 0);
        check({tag, "_reset_end"},   int'(bus_if.reset_end),   0);
        check({tag, "_suspend"},     int'(bus_if.suspend),     0);
        check({tag, "_resume"},      int'(bus_if.resume),      0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int n;
        int rise_at;
        {bus_if.dp_raw, bus_if.dm_raw} = SE0;
        repeat (3) @(negedge clk);
        check_all_idle("reset_value");
        {bus_if.dp_raw, bus_if.dm_raw} = J;
        @(negedge clk);
        rst_in = 1'b1;
        repeat (5) step(J);

        // EOP-length SE0 must be ignored.
        seen = 0;
        watch(SE0, 8, seen);
        watch(J, 20, seen);
        $display("txn eop8: activity=%0d", seen);
        check("eop_no_reset", seen, 0);

        // One cycle short of qualification.
        seen = 0;
        watch(SE0, RMIN - 1, seen);
        watch(J, 20, seen);
        $display("txn se0_119: activity=%0d", seen);
        check("se0_119_no_reset", seen, 0);

        // Qualifying SE0: bus_reset visible 122 edges after the first SE0 sample.
        n = 0;
        do begin
            step(SE0);
            n++;
        end while (!bus_if.bus_reset && n < 300);
        $display("txn se0_rise: edges=%0d", n);
        check("reset_latency", n, 122);
        check("reset_start_at_rise", int'(bus_if.reset_start), 1);
        step(SE0);
        check("reset_start_width", int'(bus_if.reset_start), 0);
        check("bus_reset_held", int'(bus_if.bus_reset), 1);
        seen = 0;
        watch(SE0, 2000 - 123, seen);
        check("bus_reset_long", int'(bus_if.bus_reset), 1);

        n = 0;
        do begin
            step(J);
            n++;
        end while (bus_if.bus_reset && n < 20);
        $display("txn reset_release: edges=%0d", n);
        check("release_latency", n, 3);
        check("reset_end_at_fall", int'(bus_if.reset_end), 1);
        step(J);
        check("reset_end_width", int'(bus_if.reset_end), 0);
        seen = 0;
        watch(J, 10, seen);

        // SE1 glitch restarts qualification: 60 SE0 + SE1 + 120 SE0.
        n = 0;
        rise_at = 0;
        for (int i = 0; i < 60; i++) begin
            step(SE0);
            n++;
            if (bus_if.bus_reset && rise_at == 0) rise_at = n;
        end
        step(SE1);
        n++;
        if (bus_if.bus_reset && rise_at == 0) rise_at = n;
        while (rise_at == 0 && n < 400) begin
            step(SE0);
            n++;
            if (bus_if.bus_reset) rise_at = n;
        end
        $display("txn se1_glitch: rise_edge=%0d", rise_at);
        check("se1_glitch_rise", rise_at, 183);
        seen = 0;
        watch(J, 10, seen);

        // Asynchronous reset while bus_reset is active.
        seen = 0;
        watch(SE0, 130, seen);
        check("pre_async_bus_reset", int'(bus_if.bus_reset), 1);
        #3;
        rst_in = 1'b0;
        #1;
        $display("txn async_reset: bus_reset=%0d", bus_if.bus_reset);
        check_all_idle("async_reset");
        @(negedge clk);
        {bus_if.dp_raw, bus_if.dm_raw} = J;
        repeat (2) @(negedge clk);
        rst_in = 1'b1;
        seen = 0;
        watch(J, 10, seen);
        check("no_reset_end_after_async", seen, 0);

`ifdef USB_SUSPEND_DETECT_EN
        @(posedge clk);
        #3;
        rst_in = 1'b0;
        @(negedge clk);
        rst_in = 1'b1;
        n = 0;
        do begin
            step(J);
            n++;
        end while (!bus_if.suspend && n < 1000);
        $display("txn suspend: edges=%0d", n);
        check("suspend_latency", n, SUSP);

        n = 0;
        do begin
            step(K);
            n++;
        end while (!bus_if.resume && n < 20);
        $display("txn resume_k: edges=%0d", n);
        check("resume_k_latency", n, 3);
        check("resume_k_suspend_low", int'(bus_if.suspend), 0);
        step(J);
        check("resume_k_width", int'(bus_if.resume), 0);

        n = 0;
        do begin
            step(J);
            n++;
        end while (!bus_if.suspend && n < 1000);
        check("resuspend", int'(bus_if.suspend), 1);
        n = 0;
        do begin
            step(SE0);
            n++;
        end while (!bus_if.resume && n < 20);
        check("resume_se0_latency", n, 3);
        while (!bus_if.bus_reset && n < 400) begin
            step(SE0);
            n++;
        end
        $display("txn reset_from_suspend: edges=%0d", n);
        check("reset_from_suspend_latency", n, 122);
        seen = 0;
        watch(J, 10, seen);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
